// File: rtl/hamming_secded_decoder.sv
// Extended-Hamming SECDED decoder with one registered output stage (valid/ready)
// and saturating single/multi error counters for link-quality monitoring.
module hamming_secded_decoder #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned CHECK_W = calc_check_w(DATA_W),
    localparam int unsigned N       = DATA_W + CHECK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N:0]         code_in,
    input  logic               correct_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic               err_single,
    output logic               err_multi,
    output logic [CHECK_W:0]   syndrome_out,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   single_count,
    output logic [CNT_W-1:0]   multi_count
);

    function automatic int unsigned calc_check_w(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned k = 1; k < 31; k++) begin
            if (r == 0 && (32'd1 << k) >= dw + k + 1) r = k;
        end
        return r;
    endfunction

    // Hamming position of data bit d: the d-th non-power-of-two position from 3 upward.
    function automatic int unsigned data_pos(input int unsigned d);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned i = 3; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (pos == 0 && cnt == d) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    localparam logic [CHECK_W-1:0] N_S     = CHECK_W'(N);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic [CHECK_W-1:0] syn;
    logic               par;
    logic               err_s;
    logic               err_m;
    logic               fix_en;
    logic               accept;
    logic [DATA_W-1:0]  data_x;

    logic               valid_q,  valid_d;
    logic [DATA_W-1:0]  data_q,   data_d;
    logic               err_s_q,  err_s_d;
    logic               err_m_q,  err_m_d;
    logic [CHECK_W:0]   syn_q,    syn_d;
    logic [CNT_W-1:0]   scnt_q,   scnt_d;
    logic [CNT_W-1:0]   mcnt_q,   mcnt_d;

    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (code_in[i]) syn = syn ^ CHECK_W'(i);
        end
        par = ^code_in;
    end

    // s==0 with p==1 means the overall parity bit itself flipped.
    assign err_s  = par && (syn <= N_S);
    assign err_m  = (par && (syn > N_S)) || (!par && (syn != '0));
    assign fix_en = correct_en && err_s;

    for (genvar g = 0; g < DATA_W; g++) begin : g_extract
        localparam int unsigned DPOS = data_pos(g);
        assign data_x[g] = code_in[DPOS] ^ (fix_en && (syn == CHECK_W'(DPOS)));
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_s_d = err_s_q;
        err_m_d = err_m_q;
        syn_d   = syn_q;
        scnt_d  = scnt_q;
        mcnt_d  = mcnt_q;

        if (accept) begin
            valid_d = 1'b1;
            data_d  = data_x;
            err_s_d = err_s;
            err_m_d = err_m;
            syn_d   = {par, syn};
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (cnt_clr) begin
            scnt_d = '0;
            mcnt_d = '0;
        end else if (accept) begin
            if (err_s && scnt_q != CNT_MAX) scnt_d = scnt_q + 1'b1;
            if (err_m && mcnt_q != CNT_MAX) mcnt_d = mcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_s_q <= 1'b0;
            err_m_q <= 1'b0;
            syn_q   <= '0;
            scnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_s_q <= err_s_d;
            err_m_q <= err_m_d;
            syn_q   <= syn_d;
            scnt_q  <= scnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign data_out     = data_q;
    assign err_single   = err_s_q;
    assign err_multi    = err_m_q;
    assign syndrome_out = syn_q;
    assign single_count = scnt_q;
    assign multi_count  = mcnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench: default decoder (CNT_W=8) and a CNT_W=2 copy driven by the same stimulus.
module tb_hamming_secded_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [12:0] code_in;
    logic        correct_en;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready, out_valid, err_single, err_multi;
    logic [7:0]  data_out;
    logic [4:0]  syndrome_out;
    logic [7:0]  single_count, multi_count;

    logic        s_in_ready, s_out_valid, s_err_single, s_err_multi;
    logic [7:0]  s_data_out;
    logic [4:0]  s_syndrome_out;
    logic [1:0]  s_single_count, s_multi_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hamming_secded_decoder #(.DATA_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .correct_en(correct_en), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .err_single(err_single),
        .err_multi(err_multi), .syndrome_out(syndrome_out), .cnt_clr(cnt_clr),
        .single_count(single_count), .multi_count(multi_count)
    );

    hamming_secded_decoder #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .code_in(code_in), .correct_en(correct_en), .out_valid(s_out_valid),
        .out_ready(out_ready), .data_out(s_data_out), .err_single(s_err_single),
        .err_multi(s_err_multi), .syndrome_out(s_syndrome_out), .cnt_clr(cnt_clr),
        .single_count(s_single_count), .multi_count(s_multi_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat, let it be accepted on the next edge, sample 1 ns later.
    task automatic send(input logic [12:0] c, input logic ce);
        in_valid   = 1'b1;
        code_in    = c;
        correct_en = ce;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic es,
                              input logic em, input logic [4:0] sy);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".data"}, data_out, d);
        check({tag, ".single"}, err_single, es);
        check({tag, ".multi"}, err_multi, em);
        check({tag, ".syn"}, syndrome_out, sy);
    endtask

    initial begin
        logic [12:0] c;
        rst_n = 1'b0; in_valid = 1'b0; code_in = '0; correct_en = 1'b1;
        out_ready = 1'b1; cnt_clr = 1'b0;
        #12;
        check("rst.valid", out_valid, 1'b0);
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.data", data_out, 8'h00);
        check("rst.scnt", single_count, 8'd0);
        check("rst.mcnt", multi_count, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // clean beat
        send(13'h144E, 1'b1);
        check_beat("clean", 8'hA5, 1'b0, 1'b0, 5'h00);
        check("clean.scnt", single_count, 8'd0);

        // every single-bit flip corrects back to 0xA5 with syndrome {1, position}
        for (int unsigned i = 0; i < 13; i++) begin
            c = 13'h144E ^ (13'h1 << i);
            send(c, 1'b1);
            check_beat($sformatf("sweep%0d", i), 8'hA5, 1'b1, 1'b0, 5'h10 | 5'(i));
        end
        check("sweep.scnt", single_count, 8'd13);
        check("sweep.sat_scnt", s_single_count, 2'd3);
        check("sweep.mcnt", multi_count, 8'd0);

        // positions 3 and 5 hold data bits 0 and 1, so raw data is 0xA5 ^ 0x03
        send(13'h1466, 1'b1);
        check_beat("double", 8'hA6, 1'b0, 1'b1, 5'h06);
        check("double.mcnt", multi_count, 8'd1);

        send(13'h140E, 1'b0);
        check_beat("detect_only", 8'hA1, 1'b1, 1'b0, 5'h16);
        check("detect_only.scnt", single_count, 8'd14);

        // flips at 1,4,8: p=1, s=13 > N
        send(13'h155C, 1'b1);
        check_beat("s_gt_n", 8'hA5, 1'b0, 1'b1, 5'h1D);
        check("s_gt_n.mcnt", multi_count, 8'd2);
        check("s_gt_n.sat_mcnt", s_multi_count, 2'd2);

        // clear wins over a simultaneously accepted error beat
        cnt_clr = 1'b1;
        send(13'h140E, 1'b1);
        cnt_clr = 1'b0;
        check_beat("clr", 8'hA5, 1'b1, 1'b0, 5'h16);
        check("clr.scnt", single_count, 8'd0);
        check("clr.mcnt", multi_count, 8'd0);
        check("clr.sat_scnt", s_single_count, 2'd0);

        for (int unsigned i = 0; i < 5; i++) begin
            send(13'h144E ^ 13'h0200, 1'b1);
            if (i == 2) check("sat.at3", s_single_count, 2'd3);
        end
        check("sat.scnt", single_count, 8'd5);
        check("sat.sat_scnt", s_single_count, 2'd3);

        // back-pressure: beats A5, FF, 01, 00 with out_ready low for 3 cycles
        in_valid = 1'b1; code_in = 13'h144E; correct_en = 1'b1;
        @(posedge clk); #1;
        check_beat("bp0", 8'hA5, 1'b0, 1'b0, 5'h00);
        code_in = 13'h1EEE; out_ready = 1'b0;
        #1;
        check("bp.in_ready_low", in_ready, 1'b0);
        for (int unsigned k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_beat($sformatf("bp_hold%0d", k), 8'hA5, 1'b0, 1'b0, 5'h00);
            check($sformatf("bp_hold%0d.in_ready", k), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", in_ready, 1'b1);
        @(posedge clk); #1;
        check_beat("bp1", 8'hFF, 1'b0, 1'b0, 5'h00);
        code_in = 13'h000F;
        @(posedge clk); #1;
        check_beat("bp2", 8'h01, 1'b0, 1'b0, 5'h00);
        code_in = 13'h0000;
        @(posedge clk); #1;
        check_beat("bp3", 8'h00, 1'b0, 1'b0, 5'h00);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp.drain", out_valid, 1'b0);
        check("bp.scnt", single_count, 8'd5);

        // asynchronous reset while a beat is held
        out_ready = 1'b0;
        send(13'h140E, 1'b1);
        check("rmid.held", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid.valid", out_valid, 1'b0);
        check("rmid.data", data_out, 8'h00);
        check("rmid.single", err_single, 1'b0);
        check("rmid.syn", syndrome_out, 5'h00);
        check("rmid.scnt", single_count, 8'd0);
        check("rmid.sat_scnt", s_single_count, 2'd0);
        check("rmid.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(13'h1EEE ^ 13'h0200, 1'b1);
        check_beat("post_rst", 8'hFF, 1'b1, 1'b0, 5'h19);
        check("post_rst.scnt", single_count, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
